// File: rtl/match_referee.sv
// match_referee: multi-round tug-of-war referee.
// Detects round wins from the player presses and edge lights, keeps both
// scores, holds the board between rounds, and then pulses a playfield
// restart. It declares the match winner when a score reaches WIN_TARGET.
// Every output is registered.
//
// Parameters:
//   WIN_TARGET  - rounds needed to win the match (1..9)
//   HOLD_CYCLES - cycles in ROUND_OVER before the restart pulse (>= 1)
// Ports:
//   clk           system clock
//   reset         synchronous active-low reset
//   L, R          left/right player press
//   LE, RE        leftmost/rightmost playfield light lit
//   left_score    binary left score
//   right_score   binary right score
//   round_restart one-cycle playfield restart pulse
//   match_over    high while the match is decided
//   winner        00 none, 01 left, 10 right
//   HEXL, HEXR    active-low 7-segment score digits
//   W             active-low winner digit ("1", "2" or blank)
// Optional build macro:
//   MATCH_REFEREE_REMATCH_EN - L&R in MATCH_OVER restarts the match
module match_referee #(
  parameter int unsigned WIN_TARGET  = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       LE,
  input  logic       RE,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       round_restart,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [6:0] HEXL,
  output logic [6:0] HEXR,
  output logic [6:0] W
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] TARGET = 4'(WIN_TARGET);

  localparam logic [1:0] PLAY       = 2'd0;
  localparam logic [1:0] ROUND_OVER = 2'd1;
  localparam logic [1:0] MATCH_OVER = 2'd2;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] hold_cnt, cnt_next;
  logic [3:0]       lscore_next, rscore_next;
  logic [1:0]       winner_next;
  logic             restart_next;
  logic             left_evt, right_evt;

  // Active-low digit encodings, segment order gfedcba
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] wseg(input logic [1:0] w);
    case (w)
      2'b01:   wseg = 7'b1111001;
      2'b10:   wseg = 7'b0100100;
      default: wseg = 7'b1111111;
    endcase
  endfunction

  // Events are mutually exclusive: a simultaneous press cancels out
  assign left_evt  = L & ~R & LE;
  assign right_evt = ~L & R & RE;

  // Next-state and next-output logic
  always_comb begin
    state_next   = state;
    cnt_next     = hold_cnt;
    lscore_next  = left_score;
    rscore_next  = right_score;
    winner_next  = winner;
    restart_next = 1'b0;

    case (state)
      PLAY: begin
        if (left_evt) begin
          lscore_next = left_score + 4'd1;
          if (lscore_next == TARGET) begin
            state_next  = MATCH_OVER;
            winner_next = 2'b01;
          end else begin
            state_next = ROUND_OVER;
            cnt_next   = '0;
          end
        end else if (right_evt) begin
          rscore_next = right_score + 4'd1;
          if (rscore_next == TARGET) begin
            state_next  = MATCH_OVER;
            winner_next = 2'b10;
          end else begin
            state_next = ROUND_OVER;
            cnt_next   = '0;
          end
        end
      end
      ROUND_OVER: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = PLAY;
          cnt_next   = '0;
        end else begin
          cnt_next = hold_cnt + CNT_W'(1);
        end
      end
      MATCH_OVER: begin
`ifdef MATCH_REFEREE_REMATCH_EN
        if (L && R) begin
          lscore_next  = 4'd0;
          rscore_next  = 4'd0;
          winner_next  = 2'b00;
          state_next   = PLAY;
          restart_next = 1'b1;
        end
`endif
      end
      default: state_next = PLAY;
    endcase

    // Pulse lands in the hold cycle whose counter value is HOLD_LAST
    if ((state_next == ROUND_OVER) && (cnt_next == HOLD_LAST)) begin
      restart_next = 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= PLAY;
      hold_cnt      <= '0;
      left_score    <= 4'd0;
      right_score   <= 4'd0;
      winner        <= 2'b00;
      round_restart <= 1'b0;
      match_over    <= 1'b0;
      HEXL          <= 7'b1000000;
      HEXR          <= 7'b1000000;
      W             <= 7'b1111111;
    end else begin
      state         <= state_next;
      hold_cnt      <= cnt_next;
      left_score    <= lscore_next;
      right_score   <= rscore_next;
      winner        <= winner_next;
      round_restart <= restart_next;
      match_over    <= (state_next == MATCH_OVER);
      HEXL          <= seg7(lscore_next);
      HEXR          <= seg7(rscore_next);
      W             <= wseg(winner_next);
    end
  end

endmodule

// File: doc/match_referee.md
Name: match_referee

Overview:
- Multi-round successor to the single-round tug-of-war winner latch.
- Detects each round win from the player inputs and edge-light status, and keeps a per-player score.
- Holds the board between rounds, then pulses a playfield restart.
- Declares the match winner when a player reaches WIN_TARGET, and drives active-low 7-segment displays for both scores and the winner.

Parameters:
WIN_TARGET, 3, rounds needed to win the match; legal range 1..9.
HOLD_CYCLES, 4, cycles spent in ROUND_OVER before the playfield restart pulse; legal range >= 1.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-low reset; sampled on posedge clk; 0 = reset.
L  input  1  left player press (already synchronised upstream).
R  input  1  right player press (already synchronised upstream).
LE  input  1  leftmost playfield light is lit.
RE  input  1  rightmost playfield light is lit.
left_score  output  4  binary left score.
right_score  output  4  binary right score.
round_restart  output  1  one-cycle pulse; the playfield returns the light to centre.
match_over  output  1  high while in the MATCH_OVER state.
winner  output  2  00 = none, 01 = left, 10 = right; 11 is never driven.
HEXL  output  7  active-low 7-segment digit of left_score.
HEXR  output  7  active-low 7-segment digit of right_score.
W  output  7  winner display: off 1111111, "1" 1111001, "2" 0100100.

Behaviour:
- All state is registered on posedge clk. Outputs are decoded from registered state only, with no combinational path from inputs to outputs.
- Reset (reset==0 at a posedge) forces the following values:
  - state=PLAY, both scores=0, hold counter=0.
  - round_restart=0, match_over=0, winner=00.
  - W=1111111, HEXL=HEXR=1000000 (digit 0).
  - Reset overrides everything, including mid-hold and MATCH_OVER.
- Round-win events are evaluated only in PLAY:
  - left_evt = L & ~R & LE
  - right_evt = ~L & R & RE
  - The two events are mutually exclusive by construction. L&R together, or a press without the matching edge light, is no event.
- State PLAY:
  - left_evt: left_score+1 at the same edge.
    - If the new score == WIN_TARGET -> MATCH_OVER with winner=01.
    - Otherwise -> ROUND_OVER with hold counter=0.
  - right_evt: same behaviour with right_score, winner=10.
  - No event: stay in PLAY.
- State ROUND_OVER:
  - All inputs are ignored.
  - The hold counter increments each cycle.
  - On the cycle where the counter == HOLD_CYCLES-1, round_restart=1 (registered, exactly one cycle) and the next state is PLAY.
  - A round-win event is therefore not evaluated until one cycle after the pulse.
  - Total time from event edge to return to PLAY is HOLD_CYCLES cycles.
- State MATCH_OVER:
  - Scores, winner and W are frozen.
  - round_restart stays 0; the playfield stays frozen.
  - Exit is only via reset (or rematch; see Optional Feature).
- Scores never exceed WIN_TARGET, so no wrap handling is needed.
- W is decoded from winner: 01 -> "1", 10 -> "2", else off.
- HEXL/HEXR use the standard active-low digit encodings for 0..9.
- Latency: event sampled at edge N -> score, HEX and W updated after edge N. round_restart is high in the cycle after edge N+HOLD_CYCLES-1.

Optional Feature:
- Macro: MATCH_REFEREE_REMATCH_EN.
- Defined:
  - In MATCH_OVER, L&R both high at a posedge clears both scores and winner, pulses round_restart for one cycle, and enters PLAY at the next edge.
  - The match then restarts without reset.
- Undefined: MATCH_OVER is left only by reset; L&R in MATCH_OVER has no effect.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> scores 0, winner 00, W=1111111, HEXL=HEXR=1000000, round_restart=0.
- Left round win: L=1,R=0,LE=1 for one cycle -> left_score=1, HEXL=1111001, state ROUND_OVER; round_restart pulses exactly 4 cycles after the event edge (HOLD_CYCLES=4).
- Invalid events in PLAY: L=1,R=1,LE=1; then L=1,LE=0; then R=1,RE=0 -> no score change, no pulse.
- Inputs during hold: right_evt asserted every cycle of ROUND_OVER -> right_score unchanged until back in PLAY.
- Match end: right wins 3 rounds (WIN_TARGET=3) -> right_score=3, winner=10, W=0100100, match_over=1, no round_restart after the third win; further events leave everything unchanged.
- Reset mid-hold, and rematch: reset=0 in the second hold cycle -> all cleared, no pulse. With MATCH_REFEREE_REMATCH_EN, L=R=1 in MATCH_OVER -> scores 0, one restart pulse, PLAY; without the macro, the same stimulus -> no change.
